// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and constants for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int          DATA_BITS    = 8;
  localparam logic [15:0] DEF_TICK_DIV = 16'h006C;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider, one-cycle tick every TICK_DIV clocks
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter logic [15:0] TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == TICK_DIV - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/uart_txd.sv
// rtl/uart_txd.sv - 8N1/8P1 UART transmitter with 4-entry byte FIFO
// Optional: define UART_TXD_STOP2_EN for two stop bits.
module uart_txd
  import uart_pkg::*;
#(
  parameter logic [15:0] TICK_DIV      = DEF_TICK_DIV,
  parameter int          TICKS_PER_BIT = 8,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       parity_en,
  input  logic       parity_kind,
  output logic       txd,
  output logic       busy,
  output logic [2:0] fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef UART_TXD_STOP2_EN
  localparam int STOP_TICKS = 2 * TICKS_PER_BIT;
`else
  localparam int STOP_TICKS = TICKS_PER_BIT;
`endif
  localparam int            TW        = $clog2(STOP_TICKS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);

  logic tick;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [2:0]    count;
  logic          push, pop, empty;

  assign empty    = (count == 3'd0);
  assign tx_ready = (count != 3'(FIFO_DEPTH));
  assign push     = tx_valid & tx_ready;
  assign fifo_cnt = count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_en_l, par_en_n, par_bit_l, par_bit_n;
  logic          txd_n, bit_done, load;

  assign busy = (state != IDLE) | (count != 3'd0);

  always_comb begin
    state_n   = state;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    shift_n   = shift;
    par_en_n  = par_en_l;
    par_bit_n = par_bit_l;
    pop       = 1'b0;
    load      = 1'b0;
    txd_n     = 1'b1;
    bit_done  = (tcnt == ((state == STOP) ? STOP_LAST : BIT_LAST));

    if (tick && state != IDLE) tcnt_n = bit_done ? '0 : tcnt + TW'(1);

    case (state)
      IDLE:   load = tick & ~empty;
      START:  if (tick && bit_done) state_n = DATA;
      DATA: begin
        if (tick && bit_done) begin
          shift_n = shift >> 1;
          bcnt_n  = bcnt + 3'd1;
          if (bcnt == 3'(DATA_BITS - 1)) state_n = par_en_l ? PARITY : STOP;
        end
      end
      PARITY: if (tick && bit_done) state_n = STOP;
      STOP: begin
        if (tick && bit_done) begin
          if (!empty) load = 1'b1;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Parity mode is captured with the byte so mid-frame input changes are ignored.
    if (load) begin
      pop       = 1'b1;
      shift_n   = mem[rptr];
      par_en_n  = parity_en;
      par_bit_n = parity_kind ^ (^mem[rptr]);
      bcnt_n    = '0;
      tcnt_n    = '0;
      state_n   = START;
    end

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      PARITY:  txd_n = par_bit_n;
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      txd       <= 1'b1;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      shift     <= shift_n;
      par_en_l  <= par_en_n;
      par_bit_l <= par_bit_n;
      txd       <= txd_n;
    end
  end

endmodule

// File: tb/tb_uart_txd.sv
// tb/tb_uart_txd.sv - scoreboard bench for uart_txd (TICK_DIV=4, 32 clk per bit)
module tb_uart_txd;

`ifdef UART_TXD_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int BITC  = 32;
  localparam int FRAME = BITC * (9 + NSTOP);

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pb;
    logic       b2b;
  } exp_t;

  logic       clk, rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, parity_en, parity_kind, txd, busy;
  logic [2:0] fifo_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic mon_en = 1'b1;
  exp_t sb[$];

  logic [7:0] pv_d [4] = '{8'h03, 8'h07, 8'h03, 8'h07};
  logic       pv_k [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       pv_p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] b5   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  uart_txd #(.TICK_DIV(16'd4), .TICKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_en   (parity_en),
    .parity_kind (parity_kind),
    .txd         (txd),
    .busy        (busy),
    .fifo_cnt    (fifo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (txd && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("start_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || sb.size() != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_reached", n < limit, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: decode each frame at mid-bit and compare against the scoreboard head.
  initial begin : monitor
    logic       prev;
    logic [7:0] got;
    exp_t       e;
    int         st_cyc, last_cyc, last_len;
    prev     = 1'b1;
    last_cyc = 0;
    last_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !txd) begin
        st_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame expected=none cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (e.b2b) chk("frame_gap", st_cyc - last_cyc, last_len);
          repeat (15) @(negedge clk);
          chk("start_bit", txd, 0);
          for (int i = 0; i < 8; i++) begin
            repeat (BITC) @(negedge clk);
            got[i] = txd;
          end
          chk("data_byte", got, e.d);
          if (e.pe) begin
            repeat (BITC) @(negedge clk);
            chk("parity_bit", txd, e.pb);
          end
          for (int s = 0; s < NSTOP; s++) begin
            repeat (BITC) @(negedge clk);
            chk("stop_bit", txd, 1);
          end
          last_cyc = st_cyc;
          last_len = BITC * (9 + NSTOP + (e.pe ? 1 : 0));
        end
      end
      prev = txd;
    end
  end

  initial begin : stim
    int n, m;
    rst_n       = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    parity_en   = 1'b0;
    parity_kind = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_cnt", fifo_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A5 no parity: latency and busy duration
    sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    push(8'hA5);
    wait_start(n);
    chk("first_latency_ok", (n >= 1 && n <= 5), 1);
    m = 0;
    while (busy && m < 1000) begin
      @(posedge clk); #1; m++;
    end
    chk("busy_fall", m, FRAME);
    wait_idle(1000);

    // parity vectors
    parity_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      parity_kind = pv_k[i];
      sb.push_back('{pv_d[i], 1'b1, pv_p[i], 1'b0});
      push(pv_d[i]);
      wait_idle(1000);
    end

    // five bytes with tx_valid held high
    parity_en = 1'b0;
    tx_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = b5[i];
      n = 0;
      while (!tx_ready && n < 1000) begin
        @(posedge clk); #1; n++;
      end
      sb.push_back('{b5[i], 1'b0, 1'b0, (i != 0)});
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    chk("full_cnt", fifo_cnt, 4);
    chk("full_ready", tx_ready, 0);
    chk("fifth_after_pop", txd, 0);
    wait_idle(5 * FRAME + 200);

    // parity kind toggled mid-frame
    parity_en   = 1'b1;
    parity_kind = 1'b0;
    sb.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    push(8'hFF);
    sb.push_back('{8'hFF, 1'b1, 1'b1, 1'b1});
    push(8'hFF);
    wait_start(n);
    repeat (100) @(posedge clk);
    #1;
    parity_kind = 1'b1;
    wait_idle(3 * FRAME);

    // reset during DATA of 5A with another byte queued
    mon_en    = 1'b0;
    parity_en = 1'b0;
    push(8'h5A);
    push(8'h3C);
    wait_start(n);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_cnt", fifo_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", fifo_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    sb.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    push(8'h5A);
    wait_idle(2 * FRAME);

    // back-to-back zeros: stop length shows in the start-to-start gap
    sb.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
    push(8'h00);
    sb.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
    push(8'h00);
    wait_idle(3 * FRAME);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txd.md
Name: uart_txd

Overview:
- Serial UART transmitter that drives a line for the LC3 board's serial receiver.
- Runs at 9600 bps from an internal tick divider.
- Sends 8 data bits LSB first, with optional parity (odd/even) and one stop bit.
- A 4-entry byte FIFO with valid/ready handshake decouples the core from the line.

Parameters:
- TICK_DIV, 16'h006C: clk cycles per baud tick; tick period = TICK_DIV cycles.
- TICKS_PER_BIT, 8: baud ticks per serial bit.
- FIFO_DEPTH, 4: entries in the byte FIFO (power of two).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async reset, active low
- tx_data  in  8  byte to enqueue
- tx_valid  in  1  tx_data valid this cycle
- tx_ready  out  1  FIFO not full; transfer occurs when tx_valid&tx_ready at posedge clk
- parity_en  in  1  1 = append parity bit
- parity_kind  in  1  1 = odd, 0 = even
- txd  out  1  serial line, idle high
- busy  out  1  frame in progress or FIFO non-empty
- fifo_cnt  out  3  number of queued bytes, 0..4

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - txd=1, busy=0, tx_ready=1, fifo_cnt=0.
  - FIFO pointers 0; state IDLE; tick counter 0; bit counter 0.
- Reset mid-frame aborts immediately; txd returns to 1 asynchronously.
- Tick: counter 0..TICK_DIV-1 runs free; tick=1 for one clk when it wraps. The bit timer advances only on tick.
- FIFO:
  - Write on tx_valid&tx_ready.
  - Read (pop) when the FSM leaves IDLE.
  - Simultaneous push and pop when full: tx_ready=0 that cycle, so the push is blocked; the pop takes effect.
  - Pointers wrap modulo FIFO_DEPTH. fifo_cnt updates the cycle after the event.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. On a tick with FIFO non-empty: pop the head into the shift register and go to START. Also latch parity_en/parity_kind and compute parity = parity_kind ^ (^byte).
  - START: txd=0 for TICKS_PER_BIT ticks.
  - DATA: txd=shift[0]. Every TICKS_PER_BIT ticks, shift right and increment the bit counter. After bit 7, go to PARITY if the latched parity_en is set, else STOP.
  - PARITY: txd = latched parity bit for TICKS_PER_BIT ticks.
  - STOP: txd=1 for TICKS_PER_BIT ticks. Then go directly to START if the FIFO is non-empty (pop then), else IDLE. There is no idle gap between back-to-back frames.
- Frame length: 10 bits without parity, 11 with, i.e. 80/88 ticks.
- Latency from the first push into an empty FIFO to the txd falling edge: at most TICK_DIV+1 clk.
- parity_en/parity_kind changes mid-frame do not affect the current frame.
- busy = (state!=IDLE) | (fifo_cnt!=0).
- txd is registered; no combinational path from inputs to txd.

Optional Feature:
- Macro UART_TXD_STOP2_EN.
- When defined: STOP lasts 2*TICKS_PER_BIT ticks (two stop bits).
- When undefined: one stop bit, as above.
- Frame timing otherwise unchanged.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - Constant DATA_BITS=8.
  - Default TICK_DIV 16'h006C.
- One sub-module: uart_baud_tick (parameter TICK_DIV; ports clk, rst_n, tick).

Test Plan:
- Use TICK_DIV=4 for sim speed.
- Push 8'hA5, parity_en=0 -> txd: 0, 1,0,1,0,0,1,0,1, 1. Each bit lasts 8 ticks (32 clk). busy falls after the stop bit.
- Push 8'h03, parity_en=1, parity_kind=1 (odd) -> parity bit=1. Push 8'h07 with odd -> parity=0. With even, the parity bits are 0 and 1 respectively.
- Push 5 bytes 11,22,33,44,55 back-to-back with tx_valid held high:
  - tx_ready deasserts with fifo_cnt=4.
  - The 5th byte is accepted after the first pop.
  - Frames are contiguous (stop bit immediately followed by start bit).
  - Output order matches push order.
- Toggle parity_kind mid-frame of 8'hFF -> current frame uses the latched kind; the next frame uses the new one.
- Assert rst_n low in DATA of 8'h5A -> txd=1 same cycle, fifo_cnt=0, busy=0. A fresh push after release sends a clean frame.
- With UART_TXD_STOP2_EN defined, send 8'h00 -> stop high lasts 16 ticks before the next start bit.
